// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: jump/branch/sequential next-PC select plus a valid-tagged PC history line.
// One-edge latency on every registered output; en low stalls sequential fetch, redirects still apply.
module pc_sequencer #(
  parameter int unsigned          WIDTH        = 64,
  parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
  parameter int unsigned          STEP         = 4,
  parameter int unsigned          OFF_W        = 26,
  parameter int unsigned          ALIGN_SHIFT  = 2,
  parameter int unsigned          HIST_DEPTH   = 2,
  parameter int unsigned          CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        br_taken,
  input  logic [WIDTH-1:0]            br_base,
  input  logic [OFF_W-1:0]            br_off,
  input  logic                        jr_taken,
  input  logic [WIDTH-1:0]            jr_target,
  input  logic                        flush,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            pc_plus,
  output logic [HIST_DEPTH*WIDTH-1:0] hist_pc,
  output logic [HIST_DEPTH-1:0]       hist_valid,
  output logic                        misalign,
  output logic [CNT_W-1:0]            redirect_cnt
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_SHIFT) - WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [WIDTH-1:0]      off_ext;
  logic [WIDTH-1:0]      br_tgt;
  logic                  redirect;
  logic                  advance;
  logic [WIDTH-1:0]      hist_q [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] valid_q;

  assign off_ext  = {{(WIDTH-OFF_W){br_off[OFF_W-1]}}, br_off};
  assign br_tgt   = br_base + (off_ext << ALIGN_SHIFT);
  assign pc_plus  = pc + WIDTH'(STEP);
  assign redirect = jr_taken | br_taken;
  assign advance  = en | redirect;

  for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
    assign hist_pc[g*WIDTH +: WIDTH] = hist_q[g];
  end
  assign hist_valid = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_VECTOR;
      misalign     <= 1'b0;
      redirect_cnt <= '0;
      valid_q      <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
    end else begin
      // Jump beats branch; both beat the stall so resolved redirects are never dropped.
      if (jr_taken) begin
        pc <= jr_target & ~ALIGN_MASK;
        if (|(jr_target & ALIGN_MASK)) misalign <= 1'b1;
      end else if (br_taken) begin
        pc <= br_tgt;
      end else if (en) begin
        pc <= pc_plus;
      end

      if (redirect && redirect_cnt != CNT_MAX) redirect_cnt <= redirect_cnt + CNT_W'(1);

      // Stage 0 valid is cleared on a redirect: the PC it captures is the wrong-path fetch.
      if (advance) begin
        hist_q[0]  <= pc;
        valid_q[0] <= ~redirect & ~flush;
        for (int k = 1; k < HIST_DEPTH; k++) begin
          hist_q[k]  <= hist_q[k-1];
          valid_q[k] <= valid_q[k-1] & ~flush;
        end
      end else if (flush) begin
        valid_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded random + directed bench for pc_sequencer (default config and a CNT_W=2 twin).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_base = '0;
  logic [25:0] br_off = '0;
  logic        jr_taken = 1'b0;
  logic [63:0] jr_target = '0;
  logic        flush = 1'b0;

  logic [63:0]  pc, pc_plus, pc2, pc_plus2;
  logic [127:0] hist_pc, hist_pc2;
  logic [1:0]   hist_valid, hist_valid2;
  logic         misalign, misalign2;
  logic [15:0]  redirect_cnt;
  logic [1:0]   redirect_cnt2;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .br_taken(br_taken), .br_base(br_base),
    .br_off(br_off), .jr_taken(jr_taken), .jr_target(jr_target), .flush(flush),
    .pc(pc), .pc_plus(pc_plus), .hist_pc(hist_pc), .hist_valid(hist_valid),
    .misalign(misalign), .redirect_cnt(redirect_cnt)
  );

  pc_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .br_taken(br_taken), .br_base(br_base),
    .br_off(br_off), .jr_taken(jr_taken), .jr_target(jr_target), .flush(flush),
    .pc(pc2), .pc_plus(pc_plus2), .hist_pc(hist_pc2), .hist_valid(hist_valid2),
    .misalign(misalign2), .redirect_cnt(redirect_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]  pc;
    logic [63:0]  pc_plus;
    logic [127:0] hist;
    logic [1:0]   hv;
    logic         mis;
    logic [15:0]  cnt;
    logic [1:0]   cnt2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference state: plain PC value, a two-entry history list, integer counters.
  logic [63:0] m_pc = '0;
  logic [63:0] m_h [2] = '{default: '0};
  logic        m_v [2] = '{default: 1'b0};
  logic        m_mis = 1'b0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc", 256'(pc), 256'(mon_e.pc));
      chk("pc_plus", 256'(pc_plus), 256'(mon_e.pc_plus));
      chk("hist_pc", 256'(hist_pc), 256'(mon_e.hist));
      chk("hist_valid", 256'(hist_valid), 256'(mon_e.hv));
      chk("misalign", 256'(misalign), 256'(mon_e.mis));
      chk("redirect_cnt", 256'(redirect_cnt), 256'(mon_e.cnt));
      chk("redirect_cnt_w2", 256'(redirect_cnt2), 256'(mon_e.cnt2));
      chk("twin_state", 256'({pc2, pc_plus2, hist_pc2[63:0], hist_valid2, misalign2}),
          256'({mon_e.pc, mon_e.pc_plus, mon_e.hist[63:0], mon_e.hv, mon_e.mis}));
    end
  end

  task automatic cyc(input logic r, input logic e, input logic b, input logic [63:0] bb,
                     input logic [25:0] bo, input logic j, input logic [63:0] jt, input logic f);
    logic   rd;
    longint off;
    exp_t   x;
    @(negedge clk);
    reset = r; en = e; br_taken = b; br_base = bb; br_off = bo;
    jr_taken = j; jr_target = jt; flush = f;
    if (r) begin
      m_pc = '0; m_h[0] = '0; m_h[1] = '0; m_v[0] = 0; m_v[1] = 0;
      m_mis = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      rd = j || b;
      if (e || rd) begin
        m_h[1] = m_h[0]; m_v[1] = m_v[0];
        m_h[0] = m_pc;   m_v[0] = !rd;
      end
      if (f) begin m_v[0] = 0; m_v[1] = 0; end
      if (j) begin
        if (jt % 4 != 0) m_mis = 1;
        m_pc = jt - (jt % 4);
      end else if (b) begin
        off  = bo[25] ? longint'(bo) - (longint'(1) << 26) : longint'(bo);
        m_pc = bb + 64'(off * 4);
      end else if (e) begin
        m_pc = m_pc + 64'd4;
      end
      if (rd) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    x.pc = m_pc; x.pc_plus = m_pc + 64'd4; x.hist = {m_h[1], m_h[0]};
    x.hv = {m_v[1], m_v[0]}; x.mis = m_mis; x.cnt = 16'(m_cnt); x.cnt2 = 2'(m_cnt2);
    exp_q.push_back(x);
  endtask

  initial begin
    // Reset, then three sequential fetches.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Jump to 0x100, branch back by two words, then forward by three.
    cyc(0, 1, 0, 0, 0, 1, 64'h100, 0);
    cyc(0, 1, 1, 64'h0F8, 26'h3FFFFFE, 0, 0, 0);
    cyc(0, 1, 1, 64'h0F8, 26'd3, 0, 0, 0);
    // Simultaneous misaligned jump and branch during a stall.
    cyc(0, 0, 1, 64'h500, 26'd7, 1, 64'h2003, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Stall holds everything; flush during stall clears only valids.
    cyc(0, 1, 0, 0, 0, 1, 64'h40, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 64'h40, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    // Address wrap on sequential increment and on branch target.
    cyc(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 64'h0, 26'h3FFFFFF, 0, 0, 0);
    // Counter saturation on the 2-bit twin, then reset landing on a redirect.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 64'h1000 * i, 26'(i), 0, 0, 0);
    cyc(1, 1, 1, 64'h100, 26'd5, 1, 64'h3003, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 59) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 5) == 0,
          {$urandom, $urandom},
          26'($urandom),
          $urandom_range(0, 7) == 0,
          ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'(32'($urandom) & 32'hFFFF_FFFC),
          $urandom_range(0, 7) == 0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised fetch-address sequencer for the pipelined 64-bit datapath, replacing the fixed single-stage program counter.
- Chooses the next PC from four sources: reset vector, register jump target, PC-relative branch target, or sequential PC+STEP.
- Computes the branch target internally.
- Carries a HIST_DEPTH-deep delay line of fetched PCs with valid bits, for the downstream IF/ID/EX stages.
- Keeps a saturating redirect counter for performance debug.

Parameters:
WIDTH, 64, address width in bits.
RESET_VECTOR, 0, PC value loaded on reset.
STEP, 4, sequential increment in bytes.
OFF_W, 26, width of the signed branch word offset.
ALIGN_SHIFT, 2, left shift applied to the branch offset; also the number of low address bits that must be zero.
HIST_DEPTH, 2, number of PC history stages (minimum 1).
CNT_W, 16, redirect counter width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high.
en  input  1  advance enable; low = fetch stall.
br_taken  input  1  PC-relative branch redirect request.
br_base  input  WIDTH  PC of the branch instruction.
br_off  input  OFF_W  signed word offset (two's complement).
jr_taken  input  1  register-jump redirect request.
jr_target  input  WIDTH  absolute jump target.
flush  input  1  invalidate all history stages.
pc  output  WIDTH  current fetch address.
pc_plus  output  WIDTH  combinational pc+STEP, modulo 2^WIDTH.
hist_pc  output  HIST_DEPTH*WIDTH  history PCs; stage k occupies bits [k*WIDTH +: WIDTH], stage 0 is the youngest.
hist_valid  output  HIST_DEPTH  per-stage valid.
misalign  output  1  sticky flag: a jump target had nonzero low ALIGN_SHIFT bits.
redirect_cnt  output  CNT_W  saturating count of accepted redirects.

Behaviour:
Reset (highest priority; reset mid-operation discards all pending requests):
- pc=RESET_VECTOR.
- hist_pc all 0, hist_valid all 0.
- misalign=0, redirect_cnt=0.

Branch target:
- br_tgt = br_base + (sign_extend(br_off) << ALIGN_SHIFT), truncated to WIDTH bits (wraps).

Next-PC priority per edge, when not in reset:
1. jr_taken=1: pc <= jr_target with low ALIGN_SHIFT bits forced to 0. If any of those bits were 1, set misalign (sticky until reset).
2. else br_taken=1: pc <= br_tgt.
3. else en=1: pc <= pc_plus (wraps at 2^WIDTH, no flag).
4. else: pc holds.

Redirect rules:
- Redirects (1 or 2) are taken regardless of en, so a resolved branch is never lost during a stall.
- jr_taken and br_taken both high: jump wins, branch ignored, counted once.

History pipeline:
- "advance" = en OR jr_taken OR br_taken.
- On advance: stage0 <= current pc and stages k <= k-1 shift.
- Valid bits:
  - Redirect: stage0 valid <= 0, marking the wrong-path fetch.
  - Sequential advance: stage0 valid <= 1.
  - Older stages' valid bits shift with their PCs.
- No advance: all stages hold.
- flush=1 clears every hist_valid bit on that edge, including the stage being loaded. hist_pc still updates per the advance rule.
- flush does not affect pc.

Redirect counter:
- Increments by 1 on each edge with a redirect accepted (jr_taken or br_taken, not in reset).
- Saturates at 2^CNT_W-1; does not wrap.

Latency and outputs:
- pc changes one edge after the request.
- pc_plus is combinational from pc.
- All other outputs are registered.

Test Plan:
- Reset then en=1 for 3 cycles (defaults) -> pc 0,4,8,12; hist_pc[0] 0,4,8 with valid=1; stage1 lags stage0 by one edge; redirect_cnt=0.
- pc=0x100, br_taken=1, br_base=0x0F8, br_off=-2 (0x3FFFFFE) -> next pc=0x0F0; hist stage0=0x100 with valid=0; redirect_cnt=1. With br_off=+3 -> pc=0x104.
- en=0 with jr_taken=1 and jr_target=0x2003, br_taken=1 simultaneously -> pc=0x2000, misalign=1 and stays 1 over the following sequential cycles; redirect_cnt increments by exactly 1.
- en=0 for 4 cycles, no redirect, pc=0x40 -> pc, hist_pc and hist_valid unchanged; then flush=1 with en=0 -> all hist_valid=0, pc still 0x40.
- pc=0xFFFF_FFFF_FFFF_FFFC, en=1 -> pc=0; br_base=0, br_off=-1 -> pc=0xFFFF_FFFF_FFFF_FFFC (target wraps).
- CNT_W=2, 5 consecutive branch redirects -> redirect_cnt 1,2,3,3,3. Assert reset during a redirect cycle -> pc=RESET_VECTOR, all history invalid, counter 0.
